mul_border_lanes: RTL and testbench
===================================

# mul_border_lanes

Multi-lane, self-timed successor to the single-lane unary-rate border multiplier. One shared input operand is multiplied against LANES independent weights by rate-coded bit streams: a low-discrepancy input stream gates a second generator that feeds the weight comparators. Each lane emits its product bit stream and a binary popcount of it. A start/done handshake frames each run. The block sits at the west border of the systolic array and feeds PE rows.

## Interface
- WIDTH, 8: operand width including sign position; magnitude width M = WIDTH-1.
- LANES, 4: number of weight lanes sharing one input operand.
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  reset; synchronous, active-high.
- i_start  in  1  request a run; sampled only in IDLE.
- i_data_i  in  M  input magnitude; captured on accepted start.
- i_data_w  in  LANES*M  lane weights, lane k at bits [k*M +: M]; captured on accepted start.
- i_len  in  M+1  run length in cycles; 0 or any value > 2^M means 2^M.
- o_busy  out  1  high in RUN.
- o_bit_vld  out  1  high on cycles where o_bit is meaningful (RUN).
- o_bit  out  LANES  per-lane product bit.
- o_valid  out  1  result available (DONE).
- i_ready  in  1  consumer accepts the result.
- o_count  out  LANES*(M+1)  per-lane popcount of o_bit over the run.

## Operation
- RNG: a generator is an M-bit counter. Its output r is the bit-reverse of the counter, i.e. van der Corput order. Counter bit 0 maps to r bit M-1.
- Input generator cI advances every RUN cycle. bitI = (dI > rev(cI)), unsigned compare.
- Weight generator cW advances only on RUN cycles where bitI = 1. bitI is common to all lanes, so one cW is shared by every lane.
- Lane k: bitW[k] = (dW[k] > rev(cW)). o_bit[k] = bitI & bitW[k]. o_count[k] increments by o_bit[k] each RUN cycle.
- Operands dI, dW and length L are registered at start. Input changes during a run have no effect.
- FSM IDLE -> RUN on i_start. In the same edge: latch operands, clear cI, cW, the cycle counter and all o_count.
- FSM RUN -> DONE when the cycle counter reaches L-1, at the edge closing the L-th RUN cycle.
- FSM DONE -> IDLE on i_ready.
- i_start in RUN or DONE is ignored and not queued. If i_start and i_ready are both high in DONE, the ready is consumed and the start is dropped.
- Counters wrap mod 2^M, but a run never exceeds 2^M cycles, so no wrap occurs within a run.
- o_count holds its value through DONE and IDLE. It is cleared only by the next accepted start or by rst.
- rst in any state: state returns to IDLE, and all counters, o_count, o_bit, o_busy, o_bit_vld and o_valid go to 0. An in-flight run is discarded.
- Full-length exactness: with L = 2^M, the total count of bitI equals dI exactly.

## Timing
- Start accepted at edge T0. RUN occupies cycles T0+1 .. T0+L, with o_busy = o_bit_vld = 1.
- o_bit is combinational from registered state and valid within the same cycle.
- o_valid rises at T0+L+1, so start-to-result latency is L+1 cycles.
- o_valid stays high until the first cycle that has i_ready = 1 and is then low on the next cycle.
- Minimum start-to-start spacing is L+2 cycles, when i_ready is tied high.
- Reset values: all outputs 0, state IDLE.

## Structure
- Package mul_border_pkg: the state enum (IDLE, RUN, DONE), the function computing M from WIDTH, and the bit-reverse function.
- Sub-module rng_vdc (parameter M; ports clk, rst, clr, en, o_rand), instantiated twice: input and weight.
- Per-lane compare/count logic is a generate loop, not a sub-module.

## Test plan
- WIDTH=8, i_len=0, dI=127, weights {64,127,0,1} -> o_count = {64,127,0,1}; o_valid at start+129.
- dI=64, w=127, full length -> count 64. dI=0 with any w -> count 0 and o_bit never high.
- i_len=4, dI=127, w=64 -> run of 4 cycles with o_bit = 1,0,1,0, count 2; o_valid at start+5.
- i_ready held low 10 cycles in DONE, with i_start pulsed meanwhile -> o_valid and o_count stable, no new run. Then i_start together with i_ready -> returns to IDLE and start is dropped.
- rst asserted mid-RUN (cycle 50) -> next cycle all outputs 0, IDLE; a subsequent start runs a clean full-length run with the expected counts.
- Randomised dI, weights and i_len against a reference model of the bit-reverse generators -> exact per-cycle o_bit and final o_count match.

Source files
------------

// File: rtl/mul_border_lanes_pkg.sv
// Shared types and helpers for the multi-lane border multiplier.
// Contents: run-control state enum, magnitude-width helper and the
// bit-reverse used to turn a counter into a van der Corput sequence.
package mul_border_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Magnitude width: the operand width minus the sign position.
  function automatic int unsigned m_of(input int unsigned width);
    return width - 1;
  endfunction

  // Reverse the low w bits of x: bit 0 lands on bit w-1.
  function automatic logic [31:0] bit_rev(input logic [31:0] x, input int unsigned w);
    logic [31:0] r;
    r = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (i < w) r[5'(w - 1 - i)] = x[5'(i)];
    end
    return r;
  endfunction

endpackage

// File: rtl/mul_border_lanes_if.sv
// Run/result bus of the multi-lane border multiplier.
// master: the side that requests runs and consumes results.
// slave : the multiplier itself.
//   i_start/i_data_i/i_data_w/i_len : run request and operands
//   o_busy/o_bit_vld/o_bit          : per-cycle product streams
//   o_valid/i_ready/o_count         : result handshake and per-lane popcounts
interface mul_border_lanes_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned LANES = 4
);
  localparam int unsigned M = mul_border_pkg::m_of(WIDTH);

  logic                     i_start;
  logic [M-1:0]             i_data_i;
  logic [LANES*M-1:0]       i_data_w;
  logic [M:0]               i_len;
  logic                     o_busy;
  logic                     o_bit_vld;
  logic [LANES-1:0]         o_bit;
  logic                     o_valid;
  logic                     i_ready;
  logic [LANES*(M+1)-1:0]   o_count;

  modport master (
    output i_start, i_data_i, i_data_w, i_len, i_ready,
    input  o_busy, o_bit_vld, o_bit, o_valid, o_count
  );

  modport slave (
    input  i_start, i_data_i, i_data_w, i_len, i_ready,
    output o_busy, o_bit_vld, o_bit, o_valid, o_count
  );

endinterface

// File: rtl/mul_border_lanes_rng_vdc.sv
// Low-discrepancy generator: M-bit counter read out bit-reversed.
// Ports: clk, rst (sync, active-high), clr (sync clear), en (advance),
// o_rand (bit-reverse of the counter, valid from registered state).
module rng_vdc
  import mul_border_pkg::*;
#(
  parameter int unsigned M = 7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [M-1:0] o_rand
);

  logic [M-1:0] cnt;

  // Counter; wraps mod 2^M.
  always_ff @(posedge clk) begin
    if (rst || clr) cnt <= '0;
    else if (en)    cnt <= cnt + M'(1);
  end

  assign o_rand = M'(bit_rev(32'(cnt), M));

endmodule

// File: rtl/mul_border_lanes.sv
// Multi-lane rate-coded multiplier at the west border of the array.
// One input magnitude is multiplied by LANES weights: the input stream
// gates a shared weight generator, each lane ANDs the two streams and
// popcounts the product over a run of L cycles.
// Ports: clk, rst (sync, active-high), bus (mul_border_lanes_if.slave).
module mul_border_lanes
  import mul_border_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned LANES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  mul_border_lanes_if.slave    bus
);

  localparam int unsigned M  = m_of(WIDTH);
  localparam int unsigned CW = M + 1;
  localparam logic [CW-1:0] FULL_LEN = CW'(1) << M;

  state_t             state, state_nxt;
  logic               start_acc, run, bit_i, len_full;
  logic [M-1:0]       d_i, len_m1, len_m1_d, cyc, r_i, r_w;
  logic [LANES*M-1:0] d_w;

  assign start_acc = (state == IDLE) && bus.i_start;
  assign run       = (state == RUN);

  // Zero or anything above 2^M selects the full-length run.
  assign len_full = (bus.i_len == '0) || (bus.i_len > FULL_LEN);
  assign len_m1_d = len_full ? '1 : M'(bus.i_len - CW'(1));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; start outside IDLE is dropped, never queued.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.i_start)    state_nxt = RUN;
      RUN:     if (cyc == len_m1)  state_nxt = DONE;
      DONE:    if (bus.i_ready)    state_nxt = IDLE;
      default:                     state_nxt = IDLE;
    endcase
  end

  // Status decode from the state register.
  always_comb begin
    bus.o_busy    = 1'b0;
    bus.o_bit_vld = 1'b0;
    bus.o_valid   = 1'b0;
    case (state)
      RUN: begin
        bus.o_busy    = 1'b1;
        bus.o_bit_vld = 1'b1;
      end
      DONE:    bus.o_valid = 1'b1;
      default: ;
    endcase
  end

  // Operand capture and run-cycle counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      d_i    <= '0;
      d_w    <= '0;
      len_m1 <= '0;
      cyc    <= '0;
    end else if (start_acc) begin
      d_i    <= bus.i_data_i;
      d_w    <= bus.i_data_w;
      len_m1 <= len_m1_d;
      cyc    <= '0;
    end else if (run) begin
      cyc    <= cyc + M'(1);
    end
  end

  rng_vdc #(.M(M)) u_rng_i (
    .clk    (clk),
    .rst    (rst),
    .clr    (start_acc),
    .en     (run),
    .o_rand (r_i)
  );

  assign bit_i = (d_i > r_i);

  // Weight generator only advances on input-stream ones; shared by all lanes.
  rng_vdc #(.M(M)) u_rng_w (
    .clk    (clk),
    .rst    (rst),
    .clr    (start_acc),
    .en     (run && bit_i),
    .o_rand (r_w)
  );

  // Per-lane compare, product bit and popcount.
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [CW-1:0] cnt;
    logic          prod;

    assign prod = run && bit_i && (d_w[k*M +: M] > r_w);

    always_ff @(posedge clk) begin
      if (rst || start_acc) cnt <= '0;
      else if (prod)        cnt <= cnt + CW'(1);
    end

    assign bus.o_bit[k]            = prod;
    assign bus.o_count[k*CW +: CW] = cnt;
  end

endmodule

// File: tb/tb_mul_border_lanes.sv
// Directed and model-checked bench for mul_border_lanes.
module tb_mul_border_lanes;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned LANES = 4;
  localparam int unsigned M     = WIDTH - 1;
  localparam int unsigned CW    = M + 1;
  localparam int unsigned FULL  = 1 << M;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mul_border_lanes_if #(.WIDTH(WIDTH), .LANES(LANES)) bus ();

  mul_border_lanes #(.WIDTH(WIDTH), .LANES(LANES)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [LANES*M-1:0] pack_w(input int w0, input int w1, input int w2, input int w3);
    return {M'(w3), M'(w2), M'(w1), M'(w0)};
  endfunction

  function automatic logic [LANES*CW-1:0] pack_c(input int c0, input int c1, input int c2, input int c3);
    return {CW'(c3), CW'(c2), CW'(c1), CW'(c0)};
  endfunction

  // Reference bit-reverse: shift counter bits in LSB-first.
  function automatic int rev_m(input int c);
    int r;
    r = 0;
    for (int b = 0; b < M; b++) r = (r << 1) | ((c >> b) & 1);
    return r;
  endfunction

  // Request a run; returns in the first RUN cycle.
  task automatic drive_start(input logic [M-1:0] di, input logic [LANES*M-1:0] w, input logic [M:0] len);
    bus.i_data_i = di;
    bus.i_data_w = w;
    bus.i_len    = len;
    bus.i_start  = 1'b1;
    step();
    bus.i_start  = 1'b0;
  endtask

  task automatic release_result();
    bus.i_ready = 1'b1;
    step();
    bus.i_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.i_start = 1'b0; bus.i_ready = 1'b0;
    bus.i_data_i = '0; bus.i_data_w = '0; bus.i_len = '0;
    repeat (3) step();
    checks++; if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.o_busy); end
    checks++; if (bus.o_bit_vld !== 1'b0) begin errors++; $display("FAIL reset_bit_vld got %b want 0", bus.o_bit_vld); end
    checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", bus.o_valid); end
    checks++; if (bus.o_bit !== '0) begin errors++; $display("FAIL reset_bit got %h want 0", bus.o_bit); end
    checks++; if (bus.o_count !== '0) begin errors++; $display("FAIL reset_count got %h want 0", bus.o_count); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_full_length();
    int lat, busy_cyc;
    lat = 1; busy_cyc = 0;
    drive_start(7'd127, pack_w(64, 127, 0, 1), 8'd0);
    for (int i = 0; i < 200 && !bus.o_valid; i++) begin
      busy_cyc += int'(bus.o_busy);
      step();
      lat++;
    end
    checks++; if (lat !== 129) begin errors++; $display("FAIL full_latency got %0d want 129", lat); end
    checks++; if (busy_cyc !== 128) begin errors++; $display("FAIL full_busy_cycles got %0d want 128", busy_cyc); end
    checks++; if (bus.o_count !== pack_c(64, 127, 0, 1)) begin
      errors++; $display("FAIL full_count got %h want %h", bus.o_count, pack_c(64, 127, 0, 1)); end
    release_result();
    checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL full_valid_drop got %b want 0", bus.o_valid); end
  endtask

  task automatic test_half_input();
    int lat;
    lat = 1;
    drive_start(7'd64, pack_w(127, 64, 1, 0), 8'd128);
    for (int i = 0; i < 200 && !bus.o_valid; i++) begin step(); lat++; end
    checks++; if (lat !== 129) begin errors++; $display("FAIL half_latency got %0d want 129", lat); end
    checks++; if (bus.o_count !== pack_c(64, 32, 1, 0)) begin
      errors++; $display("FAIL half_count got %h want %h", bus.o_count, pack_c(64, 32, 1, 0)); end
    release_result();
  endtask

  task automatic test_zero_input();
    logic [LANES-1:0] seen;
    seen = '0;
    drive_start(7'd0, pack_w(127, 127, 127, 127), 8'd255);
    for (int i = 0; i < 128; i++) begin seen |= bus.o_bit; step(); end
    checks++; if (seen !== '0) begin errors++; $display("FAIL zero_bits got %b want 0", seen); end
    checks++; if (bus.o_valid !== 1'b1) begin errors++; $display("FAIL zero_valid_at_129 got %b want 1", bus.o_valid); end
    checks++; if (bus.o_count !== '0) begin errors++; $display("FAIL zero_count got %h want 0", bus.o_count); end
    release_result();
  endtask

  // Leaves the block in DONE for test_hold_done.
  task automatic test_short_run();
    logic [LANES-1:0] exp_bits [4];
    exp_bits[0] = 4'b1011; exp_bits[1] = 4'b0010; exp_bits[2] = 4'b0011; exp_bits[3] = 4'b0010;
    drive_start(7'd127, pack_w(64, 127, 0, 1), 8'd4);
    for (int c = 0; c < 4; c++) begin
      checks++; if (bus.o_bit_vld !== 1'b1) begin errors++; $display("FAIL short_bit_vld c%0d got %b want 1", c, bus.o_bit_vld); end
      checks++; if (bus.o_bit !== exp_bits[c]) begin errors++; $display("FAIL short_bit c%0d got %b want %b", c, bus.o_bit, exp_bits[c]); end
      step();
    end
    checks++; if (bus.o_valid !== 1'b1) begin errors++; $display("FAIL short_valid_at_5 got %b want 1", bus.o_valid); end
    checks++; if (bus.o_bit_vld !== 1'b0) begin errors++; $display("FAIL short_vld_after got %b want 0", bus.o_bit_vld); end
    checks++; if (bus.o_count !== pack_c(2, 4, 0, 1)) begin
      errors++; $display("FAIL short_count got %h want %h", bus.o_count, pack_c(2, 4, 0, 1)); end
  endtask

  task automatic test_hold_done();
    logic [LANES*CW-1:0] exp_cnt;
    exp_cnt = pack_c(2, 4, 0, 1);
    bus.i_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bus.i_start  = (i % 3 == 0);
      bus.i_data_i = M'(i * 13);
      bus.i_len    = CW'(i + 1);
      step();
      checks++; if (bus.o_valid !== 1'b1) begin errors++; $display("FAIL hold_valid i%0d got %b want 1", i, bus.o_valid); end
      checks++; if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL hold_busy i%0d got %b want 0", i, bus.o_busy); end
      checks++; if (bus.o_count !== exp_cnt) begin errors++; $display("FAIL hold_count i%0d got %h want %h", i, bus.o_count, exp_cnt); end
    end
    bus.i_start = 1'b1;
    bus.i_ready = 1'b1;
    step();
    bus.i_start = 1'b0;
    bus.i_ready = 1'b0;
    checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL hold_release_valid got %b want 0", bus.o_valid); end
    checks++; if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL hold_start_dropped got %b want 0", bus.o_busy); end
    step();
    checks++; if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL hold_idle_busy got %b want 0", bus.o_busy); end
    checks++; if (bus.o_count !== exp_cnt) begin errors++; $display("FAIL hold_idle_count got %h want %h", bus.o_count, exp_cnt); end
  endtask

  task automatic test_reset_mid_run();
    int lat;
    drive_start(7'd127, pack_w(64, 127, 0, 1), 8'd0);
    repeat (49) step();
    checks++; if (bus.o_busy !== 1'b1) begin errors++; $display("FAIL rstmid_busy_before got %b want 1", bus.o_busy); end
    rst = 1'b1;
    step();
    checks++; if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b want 0", bus.o_busy); end
    checks++; if (bus.o_bit_vld !== 1'b0) begin errors++; $display("FAIL rstmid_bit_vld got %b want 0", bus.o_bit_vld); end
    checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got %b want 0", bus.o_valid); end
    checks++; if (bus.o_bit !== '0) begin errors++; $display("FAIL rstmid_bit got %b want 0", bus.o_bit); end
    checks++; if (bus.o_count !== '0) begin errors++; $display("FAIL rstmid_count got %h want 0", bus.o_count); end
    rst = 1'b0;
    step();
    lat = 1;
    drive_start(7'd127, pack_w(32, 96, 100, 127), 8'd0);
    for (int i = 0; i < 200 && !bus.o_valid; i++) begin step(); lat++; end
    checks++; if (lat !== 129) begin errors++; $display("FAIL rstmid_rerun_latency got %0d want 129", lat); end
    checks++; if (bus.o_count !== pack_c(32, 96, 100, 127)) begin
      errors++; $display("FAIL rstmid_rerun_count got %h want %h", bus.o_count, pack_c(32, 96, 100, 127)); end
    release_result();
  endtask

  task automatic test_back_to_back();
    logic [11:0] busy_pat, valid_pat;
    busy_pat  = 12'b001111001111;
    valid_pat = 12'b010000010000;
    bus.i_ready  = 1'b1;
    bus.i_start  = 1'b1;
    bus.i_data_i = 7'd127;
    bus.i_data_w = pack_w(64, 127, 0, 1);
    bus.i_len    = 8'd4;
    step();
    for (int i = 0; i < 12; i++) begin
      checks++; if (bus.o_busy !== busy_pat[i]) begin errors++; $display("FAIL b2b_busy c%0d got %b want %b", i, bus.o_busy, busy_pat[i]); end
      checks++; if (bus.o_valid !== valid_pat[i]) begin errors++; $display("FAIL b2b_valid c%0d got %b want %b", i, bus.o_valid, valid_pat[i]); end
      if (valid_pat[i]) begin
        checks++; if (bus.o_count !== pack_c(2, 4, 0, 1)) begin
          errors++; $display("FAIL b2b_count c%0d got %h want %h", i, bus.o_count, pack_c(2, 4, 0, 1)); end
      end
      step();
    end
    bus.i_start = 1'b0;
    for (int i = 0; i < 10 && (bus.o_busy || bus.o_valid); i++) step();
    checks++; if (bus.o_busy !== 1'b0 || bus.o_valid !== 1'b0) begin
      errors++; $display("FAIL b2b_drain got busy=%b valid=%b want 0 0", bus.o_busy, bus.o_valid); end
    bus.i_ready = 1'b0;
  endtask

  task automatic test_random();
    int wv[LANES];
    int cnt[LANES];
    int di, len, L, ci, cw, bi;
    logic [LANES*M-1:0]  wp;
    logic [LANES-1:0]    eb;
    logic [LANES*CW-1:0] ec;
    for (int r = 0; r < 4; r++) begin
      di = int'($urandom_range(0, FULL - 1));
      for (int k = 0; k < LANES; k++) begin
        wv[k] = int'($urandom_range(0, FULL - 1));
        wp[k*M +: M] = M'(wv[k]);
        cnt[k] = 0;
      end
      len = (r == 0) ? 0 : (r == 3) ? 200 : int'($urandom_range(1, 40));
      L   = (len == 0 || len > FULL) ? FULL : len;
      ci = 0; cw = 0;
      drive_start(M'(di), wp, CW'(len));
      for (int c = 0; c < L; c++) begin
        bi = (di > rev_m(ci)) ? 1 : 0;
        for (int k = 0; k < LANES; k++) begin
          eb[k] = (bi == 1) && (wv[k] > rev_m(cw));
          cnt[k] += int'(eb[k]);
        end
        checks++; if (bus.o_bit !== eb) begin
          errors++; $display("FAIL rand_bit r%0d c%0d got %b want %b", r, c, bus.o_bit, eb); end
        ci = (ci + 1) % FULL;
        if (bi == 1) cw = (cw + 1) % FULL;
        step();
      end
      for (int k = 0; k < LANES; k++) ec[k*CW +: CW] = CW'(cnt[k]);
      checks++; if (bus.o_valid !== 1'b1) begin errors++; $display("FAIL rand_valid r%0d got %b want 1", r, bus.o_valid); end
      checks++; if (bus.o_count !== ec) begin errors++; $display("FAIL rand_count r%0d got %h want %h", r, bus.o_count, ec); end
      release_result();
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_full_length();
    test_half_input();
    test_zero_input();
    test_short_run();
    test_hold_done();
    test_reset_mid_run();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
